// File: rtl/tiny16_mem_pkg.sv
// Shared definitions for the tiny16 memory front end: port ids and the
// ACCEPT->EXEC stage register payload.
package tiny16_mem_pkg;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int unsigned STG_DATA_W = 16;

    typedef struct packed {
        logic                  vld;
        logic                  port;
        logic                  we;
        logic                  err;
        logic [STG_DATA_W-1:0] wdata;
    } stage_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; last_grant resets to the data port so
// the fetch port wins the first contested cycle.
module rr_arb2
    import tiny16_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

    // Pointer only moves when something is actually granted.
    always_comb begin
        last_d = last_q;
        if (accept) begin
            case (valid)
                2'b01:   last_d = PORT_FETCH;
                2'b10:   last_d = PORT_DATA;
                2'b11:   last_d = ~last_q;
                default: last_d = last_q;
            endcase
        end
    end

    always_comb begin
        grant = 2'b00;
        if (accept) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data round-robin sequencer in front of the single-ported memory:
// ACCEPT loads MAR, EXEC drives the read/write strobe, response follows.
module mem_arbiter
    import tiny16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = STG_DATA_W,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              mem_addr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_in_en,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_out_en,
    input  logic [DATA_W-1:0] mem_out
);

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic              exec_ok;
    logic              rsp;
    stage_t            stg_q;
    stage_t            stg_d;

    assign valid = {p1_valid, p0_valid};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .accept (!rst),
        .grant  (grant)
    );

    // ACCEPT: winner loads MAR directly; ready never waits on EXEC.
    assign win         = grant[1];
    assign win_addr    = win ? p1_addr : p0_addr;
    assign p0_ready    = grant[0];
    assign p1_ready    = grant[1];
    assign mem_addr_en = |grant;
    assign mem_addr    = win_addr;

    always_comb begin
        stg_d       = '0;
        stg_d.vld   = |grant;
        stg_d.port  = win;
        stg_d.we    = win ? p1_we : p0_we;
        stg_d.err   = 32'(win_addr) >= MEM_SIZE;
        stg_d.wdata = STG_DATA_W'(win ? p1_wdata : p0_wdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    // EXEC: MAR already holds the address; rst drops an in-flight access.
    assign exec_ok    = !rst && stg_q.vld && !stg_q.err;
    assign mem_in_en  = exec_ok && stg_q.we;
    assign mem_out_en = exec_ok && !stg_q.we;
    assign mem_in     = DATA_W'(stg_q.wdata);

    // Reads and any out-of-range request answer; good writes are silent.
    assign rsp = stg_q.vld && (!stg_q.we || stg_q.err);

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= rsp && (stg_q.port == PORT_FETCH);
            p0_err    <= rsp && (stg_q.port == PORT_FETCH) && stg_q.err;
            p1_rvalid <= rsp && (stg_q.port == PORT_DATA);
            p1_err    <= rsp && (stg_q.port == PORT_DATA) && stg_q.err;
            if (rsp && (stg_q.port == PORT_FETCH)) begin
                p0_rdata <= stg_q.err ? '0 : mem_out;
            end
            if (rsp && (stg_q.port == PORT_DATA)) begin
                p1_rdata <= stg_q.err ? '0 : mem_out;
            end
        end
    end

endmodule
